frame_addr_gen: RTL and testbench

FRAME_ADDR_GEN -- requirements
Module: frame_addr_gen

---
 rtl/frame_addr_gen_pkg.sv | 15 +
 rtl/frame_addr_gen_edge_det.sv | 23 ++
 rtl/frame_addr_gen.sv | 158 +++++++++++++++
 tb/tb_frame_addr_gen.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_addr_gen_pkg.sv
// Shared types and default geometry for the camera frame address generator.
package frame_addr_pkg;

    localparam int unsigned DEF_IMG_W  = 160;
    localparam int unsigned DEF_IMG_H  = 120;
    localparam int unsigned DEF_ADDR_W = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/frame_addr_gen_edge_det.sv
// Registered rise/fall detector: compares the current input with its value one cycle earlier.
module edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_rise = i_d & ~r_prev;
    assign o_fall = ~i_d & r_prev;

endmodule

// File: rtl/frame_addr_gen.sv
// Turns camera vsync/href/pixel strobes into frame-buffer write addresses and strobes.
// Optional double buffering is enabled by defining FRAME_ADDR_GEN_PINGPONG_EN.
module frame_addr_gen
    import frame_addr_pkg::*;
#(
    parameter int unsigned IMG_W      = DEF_IMG_W,
    parameter int unsigned IMG_H      = DEF_IMG_H,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic              pclk,
    input  logic              in_reset,
    input  logic              start,
    input  logic              vsync,
    input  logic              href,
    input  logic              pix_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic              buf_sel,
    output logic              busy,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err
);

    localparam int unsigned COL_W = $clog2(IMG_W + 1);
    localparam int unsigned ROW_W = $clog2(IMG_H + 1);
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    if (ADDR_W < $clog2(IMG_W * IMG_H)) begin : g_addr_w_check
        $error("frame_addr_gen: ADDR_W too narrow for IMG_W*IMG_H");
    end

    state_e            r_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_en;
    logic              r_line_err;
    logic              r_frame_err;

    logic w_vs_rise;
    logic w_vs_fall;
    logic w_href_rise;
    logic w_href_fall;
    logic w_unused;

    edge_det u_vs_edge (
        .i_clk  (pclk),
        .i_rst  (in_reset),
        .i_d    (vsync),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall)
    );

    edge_det u_href_edge (
        .i_clk  (pclk),
        .i_rst  (in_reset),
        .i_d    (href),
        .o_rise (w_href_rise),
        .o_fall (w_href_fall)
    );

    assign w_unused = w_href_rise;

    always_ff @(posedge pclk) begin
        if (in_reset) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_idx       <= '0;
            r_wr_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= SYNC;
                        r_line_err  <= 1'b0;
                        r_frame_err <= 1'b0;
                    end
                end
                SYNC: begin
                    if (w_vs_fall) begin
                        r_state <= ACTIVE;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_idx   <= '0;
                    end
                end
                ACTIVE: begin
                    if (href && pix_valid) begin
                        if (r_col < COL_MAX) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_idx;
                            r_idx     <= r_idx + 1'b1;
                            r_col     <= r_col + 1'b1;
                        end else begin
                            r_line_err <= 1'b1;
                        end
                    end
                    // Line close wins over a coincident vsync rise on the final line.
                    if (w_href_fall && (r_col != '0)) begin
                        r_row <= r_row + 1'b1;
                        r_col <= '0;
                        if (r_col != COL_MAX) begin
                            r_line_err <= 1'b1;
                        end
                        if (r_row == ROW_LAST) begin
                            r_state <= DONE;
                        end else if (w_vs_rise) begin
                            r_frame_err <= 1'b1;
                            r_state     <= SYNC;
                        end
                    end else if (w_vs_rise) begin
                        r_frame_err <= 1'b1;
                        r_state     <= SYNC;
                    end
                end
                DONE: begin
                    r_state <= CONTINUOUS ? SYNC : IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_ADDR_GEN_PINGPONG_EN
    logic r_buf_sel;

    always_ff @(posedge pclk) begin
        if (in_reset) begin
            r_buf_sel <= 1'b0;
        end else if (r_state == DONE) begin
            r_buf_sel <= ~r_buf_sel;
        end
    end

    assign buf_sel = r_buf_sel;
`else
    assign buf_sel = 1'b0;
`endif

    assign wr_addr    = r_wr_addr;
    assign wr_en      = r_wr_en;
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == DONE);
    assign line_err   = r_line_err;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_frame_addr_gen.sv
// Self-checking bench for frame_addr_gen on a 4x3 image: table-driven frames plus hand sequences,
// with a write-address scoreboard. Instance u_dut_b runs in continuous mode.
module tb_frame_addr_gen;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned AW = 4;

    logic          pclk = 1'b0;
    logic          in_reset, rst_b, start, vsync, href, pix_valid;
    logic [AW-1:0] wr_addr, b_wr_addr;
    logic          wr_en, buf_sel, busy, frame_done, line_err, frame_err;
    logic          b_wr_en, b_buf_sel, b_busy, b_frame_done, b_line_err, b_frame_err;
    logic          use_b;

    always #5 pclk = ~pclk;

    frame_addr_gen #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CONTINUOUS(1'b0)) u_dut (
        .pclk       (pclk),
        .in_reset   (in_reset),
        .start      (start),
        .vsync      (vsync),
        .href       (href),
        .pix_valid  (pix_valid),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .buf_sel    (buf_sel),
        .busy       (busy),
        .frame_done (frame_done),
        .line_err   (line_err),
        .frame_err  (frame_err)
    );

    frame_addr_gen #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CONTINUOUS(1'b1)) u_dut_b (
        .pclk       (pclk),
        .in_reset   (rst_b),
        .start      (start),
        .vsync      (vsync),
        .href       (href),
        .pix_valid  (pix_valid),
        .wr_addr    (b_wr_addr),
        .wr_en      (b_wr_en),
        .buf_sel    (b_buf_sel),
        .busy       (b_busy),
        .frame_done (b_frame_done),
        .line_err   (b_line_err),
        .frame_err  (b_frame_err)
    );

    // Monitored view: whichever instance the current test exercises.
    int m_addr, m_en, m_fd, m_busy, m_le, m_fe, m_bs;
    always_comb begin
        m_addr = use_b ? int'(b_wr_addr) : int'(wr_addr);
        m_en   = use_b ? int'(b_wr_en) : int'(wr_en);
        m_fd   = use_b ? int'(b_frame_done) : int'(frame_done);
        m_busy = use_b ? int'(b_busy) : int'(busy);
        m_le   = use_b ? int'(b_line_err) : int'(line_err);
        m_fe   = use_b ? int'(b_frame_err) : int'(frame_err);
        m_bs   = use_b ? int'(b_buf_sel) : int'(buf_sel);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int exp_q[$];
    int m_col, m_row, m_idx;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(negedge pclk) begin
        int e;
        if (m_en != 0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", m_addr, -1);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", m_addr, e);
            end
        end
        if (m_fd != 0) done_cnt++;
    end

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic run_frame(input int p0, input int p1, input int p2, input int nl,
                             input bit vs_fall, input bit vs_after, input bit do_start,
                             output int fd_at_fall);
        int pc[3];
        pc = '{p0, p1, p2};
        fd_at_fall = 0;
        start = do_start;
        vsync = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        vsync = 1'b0;
        m_col = 0;
        m_row = 0;
        m_idx = 0;
        cyc();
        cyc();
        for (int l = 0; l < nl; l++) begin
            href = 1'b1;
            cyc();
            for (int k = 0; k < pc[l]; k++) begin
                pix_valid = 1'b1;
                if (m_col < int'(W) && m_row < int'(H)) begin
                    exp_q.push_back(m_idx);
                    m_idx++;
                    m_col++;
                end
                cyc();
                pix_valid = 1'b0;
                cyc();
            end
            href = 1'b0;
            if (l == nl - 1 && vs_fall) vsync = 1'b1;
            cyc();
            if (m_col > 0) begin
                m_row++;
                m_col = 0;
            end
            if (l == nl - 1) begin
                @(negedge pclk);
                fd_at_fall = m_fd;
            end
            cyc();
            cyc();
        end
        if (vs_after) begin
            vsync = 1'b1;
            cyc();
            cyc();
        end
    endtask

    typedef struct {
        string name;
        int    p0, p1, p2, nl;
        bit    vs_fall, vs_after;
        int    le, fe, done, busy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fd, d0;
        vecs[0] = '{"full",       4, 4, 4, 3, 1'b0, 1'b0, 0, 0, 1, 0};
        vecs[1] = '{"short_l2",   4, 3, 4, 3, 1'b0, 1'b0, 1, 0, 1, 0};
        vecs[2] = '{"long_l2",    4, 6, 4, 3, 1'b0, 1'b0, 1, 0, 1, 0};
        vecs[3] = '{"abort_2l",   4, 4, 4, 2, 1'b0, 1'b1, 0, 1, 0, 1};
        vecs[4] = '{"vs_on_last", 4, 4, 4, 3, 1'b1, 1'b0, 0, 0, 1, 0};
        vecs[5] = '{"vs_on_l2",   4, 4, 4, 2, 1'b1, 1'b0, 0, 1, 0, 1};
        vecs[6] = '{"short_l1",   2, 4, 4, 3, 1'b0, 1'b0, 1, 0, 1, 0};

        use_b = 1'b0;
        in_reset = 1'b1;
        rst_b = 1'b1;
        start = 1'b0;
        vsync = 1'b0;
        href = 1'b0;
        pix_valid = 1'b0;
        cyc();
        cyc();
        @(negedge pclk);
        check("rst_wr_en", m_en, 0);
        check("rst_wr_addr", m_addr, 0);
        check("rst_busy", m_busy, 0);
        check("rst_frame_done", m_fd, 0);
        check("rst_line_err", m_le, 0);
        check("rst_frame_err", m_fe, 0);
        check("rst_buf_sel", m_bs, 0);

        foreach (vecs[i]) begin
            in_reset = 1'b1;
            cyc();
            in_reset = 1'b0;
            cyc();
            d0 = done_cnt;
            run_frame(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].nl,
                      vecs[i].vs_fall, vecs[i].vs_after, 1'b1, fd);
            cyc();
            cyc();
            @(negedge pclk);
            check({vecs[i].name, "_line_err"}, m_le, vecs[i].le);
            check({vecs[i].name, "_frame_err"}, m_fe, vecs[i].fe);
            check({vecs[i].name, "_done_cnt"}, done_cnt - d0, vecs[i].done);
            check({vecs[i].name, "_done_timing"}, fd, vecs[i].done);
            check({vecs[i].name, "_busy"}, m_busy, vecs[i].busy);
            check({vecs[i].name, "_pending_writes"}, exp_q.size(), 0);
            check({vecs[i].name, "_addr_hold"}, m_addr, m_idx - 1);
        end

        // Abort after two lines, then the next frame restarts at address 0 without a new start.
        in_reset = 1'b1;
        cyc();
        in_reset = 1'b0;
        cyc();
        d0 = done_cnt;
        run_frame(4, 4, 4, 2, 1'b0, 1'b1, 1'b1, fd);
        @(negedge pclk);
        check("abort_state_sync", m_busy, 1);
        check("abort_frame_err", m_fe, 1);
        run_frame(4, 4, 4, 3, 1'b0, 1'b0, 1'b0, fd);
        cyc();
        @(negedge pclk);
        check("restart_done_cnt", done_cnt - d0, 1);
        check("restart_pending", exp_q.size(), 0);
        check("restart_last_addr", m_addr, int'(W * H) - 1);
        check("restart_frame_err_sticky", m_fe, 1);
        check("restart_idle", m_busy, 0);

        // Reset in the middle of an over-long first line, coincident with a pixel.
        in_reset = 1'b1;
        cyc();
        in_reset = 1'b0;
        start = 1'b1;
        vsync = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        vsync = 1'b0;
        cyc();
        cyc();
        href = 1'b1;
        cyc();
        for (int k = 0; k < 6; k++) begin
            pix_valid = 1'b1;
            if (k < int'(W)) exp_q.push_back(k);
            cyc();
            pix_valid = 1'b0;
            cyc();
        end
        @(negedge pclk);
        check("midline_line_err", m_le, 1);
        check("midline_addr", m_addr, 3);
        pix_valid = 1'b1;
        in_reset = 1'b1;
        cyc();
        pix_valid = 1'b0;
        @(negedge pclk);
        check("midrst_wr_en", m_en, 0);
        check("midrst_wr_addr", m_addr, 0);
        check("midrst_busy", m_busy, 0);
        check("midrst_frame_done", m_fd, 0);
        check("midrst_line_err", m_le, 0);
        check("midrst_frame_err", m_fe, 0);
        check("midrst_buf_sel", m_bs, 0);
        in_reset = 1'b0;
        cyc();
        href = 1'b0;
        cyc();
        cyc();
        @(negedge pclk);
        check("midrst_stays_idle", m_busy, 0);
        check("midrst_pending", exp_q.size(), 0);

        // Continuous mode: two back-to-back frames on the second instance.
        in_reset = 1'b1;
        use_b = 1'b1;
        rst_b = 1'b1;
        cyc();
        rst_b = 1'b0;
        cyc();
        @(negedge pclk);
        check("cont_buf_sel_0", m_bs, 0);
        d0 = done_cnt;
        run_frame(4, 4, 4, 3, 1'b0, 1'b0, 1'b1, fd);
        cyc();
        @(negedge pclk);
        check("cont_f1_done_timing", fd, 1);
        check("cont_f1_rearmed", m_busy, 1);
`ifdef FRAME_ADDR_GEN_PINGPONG_EN
        check("cont_buf_sel_1", m_bs, 1);
`else
        check("cont_buf_sel_1", m_bs, 0);
`endif
        run_frame(4, 4, 4, 3, 1'b0, 1'b0, 1'b0, fd);
        cyc();
        @(negedge pclk);
        check("cont_f2_done_timing", fd, 1);
        check("cont_buf_sel_2", m_bs, 0);
        check("cont_done_cnt", done_cnt - d0, 2);
        check("cont_pending", exp_q.size(), 0);
        check("cont_line_err", m_le, 0);
        check("cont_frame_err", m_fe, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
